// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared unload FSM states and bank address width for the NTT datapath
`ifndef RING_SIZE
`define RING_SIZE 256
`endif
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } ntt_state_e;

    // Each bank holds half the ring, so one bit fewer than the full index.
    function automatic int calc_addr_w(input int ring_size);
        return $clog2(ring_size) - 1;
    endfunction

    localparam int ADDR_W = calc_addr_w(`RING_SIZE);

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - two-entry FIFO absorbing RAM returns while the consumer stalls
module stream_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign dout      = r_mem[r_rptr];
    assign valid     = (r_count != 2'd0);
    assign full      = (r_count == 2'd2);
    assign occupancy = r_count;

endmodule

// File: rtl/poly_unload.sv
// rtl/poly_unload.sv - streams one polynomial out of two RAM banks in natural coefficient order
`ifndef RING_SIZE
`define RING_SIZE 256
`endif
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module poly_unload
    import ntt_pkg::*;
#(
    parameter int  RING_SIZE     = `RING_SIZE,
    parameter int  DATA_SIZE_ARB = `DATA_SIZE_ARB,
    localparam int AW            = calc_addr_w(RING_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_SIZE_ARB-1:0] ram1_dout,
    input  logic [DATA_SIZE_ARB-1:0] ram2_dout,
    output logic                     ram1_re,
    output logic                     ram2_re,
    output logic [AW-1:0]            addr,
    output logic [DATA_SIZE_ARB-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     busy,
    output logic                     done
);

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(RING_SIZE - 1);

    ntt_state_e               r_state;
    logic [AW:0]              r_idx;
    logic                     r_inflight;
    logic                     r_inf_bank;
    logic [AW-1:0]            r_addr;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_pop;
    logic                     w_full;
    logic                     w_valid;
    logic [1:0]               w_occ;
    logic [2:0]               w_pending;
    logic                     w_issue;
    logic [DATA_SIZE_ARB-1:0] w_din;

    // Beats that will occupy the FIFO once this cycle's pop and RAM return settle;
    // a new read may only be launched if it still has a slot to land in.
    assign w_pending = {1'b0, w_occ} - {2'b0, w_pop} + {2'b0, r_inflight};
    assign w_pop     = w_valid && dout_ready;
    assign w_issue   = (r_state == ST_READ) && (w_pending < 3'd2) && (!w_full || w_pop);
    assign w_din     = r_inf_bank ? ram2_dout : ram1_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_inflight <= 1'b0;
            r_inf_bank <= 1'b0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_inf_bank <= r_idx[AW];
            if (w_issue) begin
                r_addr <= r_idx[AW-1:0];
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_READ;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pending == 3'd0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    stream_skid_buf #(
        .WIDTH(DATA_SIZE_ARB)
    ) u_out_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (r_inflight),
        .din      (w_din),
        .full     (w_full),
        .pop      (w_pop),
        .dout     (dout),
        .valid    (w_valid),
        .occupancy(w_occ)
    );

    assign ram1_re    = w_issue && !r_idx[AW];
    assign ram2_re    = w_issue && r_idx[AW];
    assign addr       = w_issue ? r_idx[AW-1:0] : r_addr;
    assign dout_valid = w_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_poly_unload.sv
// tb/tb_poly_unload.sv - directed bench for poly_unload with a scoreboard of the natural-order stream
module tb_poly_unload;

    localparam int RS   = 16;
    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int HALF = RS / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] ram1_dout = '0;
    logic [DW-1:0] ram2_dout = '0;
    logic          ram1_re;
    logic          ram2_re;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          done;

    poly_unload #(
        .RING_SIZE    (RS),
        .DATA_SIZE_ARB(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ram1_dout (ram1_dout),
        .ram2_dout (ram2_dout),
        .ram1_re   (ram1_re),
        .ram2_re   (ram2_re),
        .addr      (addr),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Banks preloaded with value = global coefficient index, one-cycle read latency.
    logic [DW-1:0] bank1 [HALF];
    logic [DW-1:0] bank2 [HALF];
    initial begin
        for (int i = 0; i < HALF; i++) begin
            bank1[i] = DW'(i);
            bank2[i] = DW'(i + HALF);
        end
    end
    always @(posedge clk) begin
        if (ram1_re) ram1_dout <= bank1[addr];
        if (ram2_re) ram2_dout <= bank2[addr];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: the stream must be 0..RS-1 once each, reads must follow the same order.
    int            exp_beat;
    int            exp_issue;
    int            n_done;
    int            first_valid_cyc;
    int            last_beat_cyc;
    logic          prev_stall;
    logic [DW-1:0] prev_dout;
    logic          mon_en = 1'b0;
    logic          rec_bank [RS];
    int            rec_addr [RS];

    task automatic model_clear();
        exp_beat        = 0;
        exp_issue       = 0;
        n_done          = 0;
        first_valid_cyc = -1;
        last_beat_cyc   = -1;
        prev_stall      = 1'b0;
        prev_dout       = '0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ram1_re && ram2_re) check("both_re", 1, 0);
            if (ram1_re || ram2_re) begin
                check("issue_in_range", exp_issue < RS, 1);
                check("issue_bank", ram2_re, exp_issue >= HALF);
                check("issue_addr", addr, exp_issue % HALF);
                if (exp_issue < RS) begin
                    rec_bank[exp_issue] = ram2_re;
                    rec_addr[exp_issue] = int'(addr);
                end
                exp_issue++;
            end
            if (prev_stall) begin
                check("stall_valid", dout_valid, 1);
                check("stall_data", dout, prev_dout);
            end
            if (dout_valid && dout_ready) begin
                check("beat_value", dout, exp_beat);
                if (exp_beat == 0) first_valid_cyc = cyc;
                exp_beat++;
                last_beat_cyc = cyc;
            end
            if (exp_issue - exp_beat > 2) check("outstanding", exp_issue - exp_beat, 2);
            if (dout_valid) check("busy_while_valid", busy, 1);
            if (done) begin
                n_done++;
                check("done_after_all", exp_beat, RS);
                check("done_timing", cyc, last_beat_cyc + 1);
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram1_re"}, ram1_re, 0);
        check({tag, "_ram2_re"}, ram2_re, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic do_start(output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    function automatic logic ready_pat(input int k);
        return ((k % 4) == 0) || ((k % 4) == 3);
    endfunction

    task automatic drive_until_done(input int mode, input int restart_at, input int budget);
        bit restarted = 1'b0;
        int k = 0;
        while (n_done == 0 && k < budget) begin
            @(posedge clk); #1;
            start      = 1'b0;
            dout_ready = (mode == 1) ? ready_pat(k) : 1'b1;
            if (restart_at >= 0 && !restarted && exp_beat == restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            k++;
        end
        check("done_within_budget", n_done != 0, 1);
        @(posedge clk); #1;
        start      = 1'b0;
        dout_ready = 1'b1;
    endtask

    task automatic check_quiet_end(input string tag);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_beats"}, exp_beat, RS);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_valid_idle"}, dout_valid, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    int t0;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        dout_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Full-rate unload.
        model_clear();
        do_start(t0);
        check("busy_after_start", busy, 1);
        drive_until_done(0, -1, 200);
        check("first_valid_latency", first_valid_cyc - t0, 2);
        check("full_rate", last_beat_cyc - first_valid_cyc, RS - 1);
        check("bank_idx7", rec_bank[7], 0);
        check("addr_idx7", rec_addr[7], 7);
        check("bank_idx8", rec_bank[8], 1);
        check("addr_idx8", rec_addr[8], 0);
        check("bank_idx15", rec_bank[15], 1);
        check("addr_idx15", rec_addr[15], 7);
        check_quiet_end("fullrate");

        // Backpressure pattern 1,0,0,1.
        model_clear();
        do_start(t0);
        drive_until_done(1, -1, 300);
        check_quiet_end("toggle");

        // Reset after beat 5 has transferred.
        model_clear();
        do_start(t0);
        for (int k = 0; k < 100 && exp_beat < 6; k++) begin
            @(posedge clk); #1;
        end
        check("reached_beat5", exp_beat, 6);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs("midreset");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("post_reset_no_valid", dout_valid, 0);
        end
        model_clear();
        mon_en = 1'b1;
        do_start(t0);
        drive_until_done(0, -1, 200);
        check_quiet_end("after_reset");

        // Reset and start together: reset wins.
        mon_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check("reset_over_start_busy", busy, 0);
        @(posedge clk); #1;
        check("reset_over_start_re", ram1_re, 0);
        model_clear();
        mon_en = 1'b1;

        // Second start while busy at beat 3 is ignored.
        model_clear();
        do_start(t0);
        drive_until_done(0, 3, 200);
        check_quiet_end("restart");

        // Consumer stalled 20 cycles after start.
        model_clear();
        dout_ready = 1'b0;
        do_start(t0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads_issued", exp_issue, 2);
        check("stall_held_valid", dout_valid, 1);
        check("stall_held_data", dout, 0);
        check("stall_no_beats", exp_beat, 0);
        drive_until_done(0, -1, 200);
        check_quiet_end("stall20");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/poly_unload.md
POLY_UNLOAD -- requirements
Module: poly_unload

Interface
REQ-001 Parameter RING_SIZE, default `RING_SIZE (defines.v), polynomial length in coefficients; power of two, >= 4.
REQ-002 Parameter DATA_SIZE_ARB, default `DATA_SIZE_ARB (defines.v), coefficient width in bits.
REQ-003 Derived constant ADDR_W = $clog2(RING_SIZE) - 1, the per-bank address width.
REQ-004 clk  in  1  sole clock; all logic is on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to unload one full polynomial.
REQ-007 ram1_dout  in  DATA_SIZE_ARB  read data of bank 1 (indices 0..RING_SIZE/2-1), valid one cycle after ram1_re.
REQ-008 ram2_dout  in  DATA_SIZE_ARB  read data of bank 2 (indices RING_SIZE/2..RING_SIZE-1), valid one cycle after ram2_re.
REQ-009 ram1_re, ram2_re  out  1 each  bank read enables; never both high.
REQ-010 addr  out  ADDR_W  bank-local read address.
REQ-011 dout  out  DATA_SIZE_ARB  output coefficient.
REQ-012 dout_valid  out  1  dout holds a coefficient.
REQ-013 dout_ready  in  1  downstream accepts; a beat transfers when dout_valid && dout_ready.
REQ-014 busy  out  1  unload in progress.
REQ-015 done  out  1  one-cycle pulse after the last beat transfers.

Function
REQ-016 The block SHALL emit coefficients in natural order, index 0 to RING_SIZE-1, exactly once each per start.
REQ-017 Index i < RING_SIZE/2 SHALL read bank 1 at addr=i; otherwise bank 2 at addr=i-RING_SIZE/2.
REQ-018 FSM states: IDLE, READ, DRAIN, DONE; IDLE->READ on start; READ->DRAIN after read index RING_SIZE-1 is issued; DRAIN->DONE when output buffer and in-flight read are empty; DONE->IDLE after one cycle.
REQ-019 start in any state other than IDLE SHALL be ignored.
REQ-020 A read SHALL be issued only when (buffered beats + in-flight reads) < 2, so no returned data is ever lost.
REQ-021 Returned RAM data SHALL be selected by the bank registered at issue time and written into a 2-entry output FIFO.
REQ-022 With dout_ready held high, first dout_valid SHALL occur 2 cycles after start, and throughput SHALL be one beat per cycle.
REQ-023 While dout_valid && !dout_ready, dout SHALL remain stable and no beat SHALL be dropped or duplicated.
REQ-024 The index counter SHALL be ADDR_W+1 bits and SHALL NOT wrap past RING_SIZE-1 within one unload.
REQ-025 busy SHALL be high in READ and DRAIN; done SHALL be high only in DONE.
REQ-026 When not issuing a read, ram1_re and ram2_re SHALL be 0 and addr SHALL hold its last value.

Reset
REQ-027 On reset: state IDLE, counter 0, FIFO empty, in-flight flag 0, dout 0, dout_valid 0, ram1_re 0, ram2_re 0, addr 0, busy 0, done 0.
REQ-028 Reset mid-unload SHALL abort immediately; any in-flight RAM data returned the next cycle SHALL be discarded.
REQ-029 Reset SHALL take priority over start in the same cycle.

Structure
REQ-030 The FSM state enum and ADDR_W SHALL live in a shared package ntt_pkg; RING_SIZE and DATA_SIZE_ARB remain in defines.v.
REQ-031 The 2-entry output FIFO SHALL be a sub-module stream_skid_buf (parameter width, ports push/din/full, pop/dout/valid, occupancy).

Verification
REQ-032 RING_SIZE=16, banks preloaded with value=index, dout_ready=1, start -> dout 0..15 on consecutive cycles starting 2 cycles after start, done pulse once after beat 15.
REQ-033 Same preload, dout_ready toggled 1,0,0,1 repeating -> output sequence still exactly 0..15, dout stable while stalled, at most 2 reads outstanding.
REQ-034 Check bank select: index 7 -> ram1_re=1, addr=7; index 8 -> ram2_re=1, addr=0; index 15 -> ram2_re=1, addr=7.
REQ-035 Assert reset after beat 5 transfers -> next cycle all outputs at reset values, no further dout_valid; new start then yields 0..15 from the beginning.
REQ-036 Pulse start again while busy at beat 3 -> ignored; exactly 16 beats and one done pulse.
REQ-037 dout_ready=0 for 20 cycles after start -> exactly 2 reads issued, dout=0 held valid; on release sequence resumes 0..15.
